rx_frame_ctrl: RTL

//  Sequences the byte stream from the RGMII receive path (data/active after preamble+SFD strip) into
//  the shared receive frame buffer. Filters on destination MAC, enforces frame length limits, handles

---
 rtl/rx_frame_ctrl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/rx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// rx_frame_ctrl
//
// Purpose
//   Moves the received byte stream (preamble/SFD already stripped) into the
//   shared receive frame buffer. Each frame is written speculatively from its
//   first byte. The block filters on destination MAC and enforces minimum and
//   maximum frame length. It drops a frame if the buffer fills. For every
//   frame that leaves IDLE it issues exactly one commit or abort pulse to the
//   buffer write-pointer logic. It also keeps saturating good/dropped frame
//   counters for the status registers.
//
// Ports
//   clk_i           receive clock, inputs sampled on posedge
//   rst_ni          asynchronous active-low reset
//   rx_data_i       payload byte, valid while rx_active_i = 1
//   rx_active_i     high for every payload byte, first low cycle ends frame
//   local_mac_i     station address, first wire byte = local_mac_i[47:40]
//   promiscuous_i   accept any destination address
//   wr_full_i       buffer cannot accept a byte this cycle
//   wr_en_o         buffer write strobe (one cycle after the byte is sampled)
//   wr_data_o       buffer write byte
//   frame_commit_o  1-cycle pulse, publish the frame just written
//   frame_abort_o   1-cycle pulse, rewind write pointer to last commit
//   frame_len_o     length of the last committed frame, held until next commit
//   good_cnt_o      committed frame count, saturating
//   drop_cnt_o      aborted frame count, saturating
// ---------------------------------------------------------------------------
//   state     | meaning
//   ----------+----------------------------------------------------------
//   S_IDLE    | waiting for first byte of a frame
//   S_DEST    | bytes 1..6, destination MAC compare, bytes written
//   S_BODY    | address accepted, bytes written until end / full / oversize
//   S_DISCARD | frame rejected, bytes ignored until rx_active_i drops
//   S_END     | single cycle carrying the commit/abort pulse
// ---------------------------------------------------------------------------
module rx_frame_ctrl #(
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1536,
    parameter int LEN_W     = 11
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [7:0]       rx_data_i,
    input  logic             rx_active_i,
    input  logic [47:0]      local_mac_i,
    input  logic             promiscuous_i,
    input  logic             wr_full_i,
    output logic             wr_en_o,
    output logic [7:0]       wr_data_o,
    output logic             frame_commit_o,
    output logic             frame_abort_o,
    output logic [LEN_W-1:0] frame_len_o,
    output logic [15:0]      good_cnt_o,
    output logic [15:0]      drop_cnt_o
);

    localparam logic [LEN_W-1:0] MinLen = LEN_W'(MIN_FRAME);
    localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_FRAME);
    localparam logic [LEN_W-1:0] OvfLen = LEN_W'(MAX_FRAME + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DEST    = 3'd1,
        S_BODY    = 3'd2,
        S_DISCARD = 3'd3,
        S_END     = 3'd4
    } state_e;

    state_e           state_q;
    logic [LEN_W-1:0] cnt_q;
    logic             match_local_q;
    logic             match_bcast_q;
    logic             wr_en_q;
    logic [7:0]       wr_data_q;
    logic             commit_q;
    logic             abort_q;
    logic [LEN_W-1:0] frame_len_q;
    logic [15:0]      good_cnt_q;
    logic [15:0]      drop_cnt_q;

    logic [LEN_W-1:0] cnt_inc_d;
    logic [7:0]       mac_byte_d;
    logic             byte_local_d;
    logic             byte_bcast_d;
    logic             accept_d;
    logic             good_frame_d;
    logic [15:0]      good_inc_d;
    logic [15:0]      drop_inc_d;

    always_comb begin
        // Count stops one past the limit so an oversized frame never wraps
        // back into the accepted length range.
        cnt_inc_d = (cnt_q == OvfLen) ? OvfLen : cnt_q + LEN_W'(1);

        // Expected address byte for the byte arriving now (count + 1).
        // Byte 1 is compared directly when the frame starts.
        mac_byte_d = local_mac_i[7:0];
        case (cnt_q[2:0])
            3'd1:    mac_byte_d = local_mac_i[39:32];
            3'd2:    mac_byte_d = local_mac_i[31:24];
            3'd3:    mac_byte_d = local_mac_i[23:16];
            3'd4:    mac_byte_d = local_mac_i[15:8];
            default: mac_byte_d = local_mac_i[7:0];
        endcase

        byte_local_d = (rx_data_i == mac_byte_d);
        byte_bcast_d = (rx_data_i == 8'hFF);

        // A station address with the group bit set would otherwise let
        // multicast through on an exact match.
        accept_d = promiscuous_i
                 | (match_local_q & byte_local_d & ~local_mac_i[40])
                 | (match_bcast_q & byte_bcast_d);

        // DEST and DISCARD endings always abort. BODY never exceeds MaxLen.
        good_frame_d = (state_q == S_BODY) && (cnt_q >= MinLen) && (cnt_q <= MaxLen);

        good_inc_d = (good_cnt_q == 16'hFFFF) ? good_cnt_q : good_cnt_q + 16'd1;
        drop_inc_d = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            match_local_q <= 1'b0;
            match_bcast_q <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_data_q     <= 8'h00;
            commit_q      <= 1'b0;
            abort_q       <= 1'b0;
            frame_len_q   <= '0;
            good_cnt_q    <= 16'h0000;
            drop_cnt_q    <= 16'h0000;
        end else begin
            wr_en_q  <= 1'b0;
            commit_q <= 1'b0;
            abort_q  <= 1'b0;

            case (state_q)
                // END behaves like IDLE so a byte in the END cycle starts
                // the next frame without losing it.
                S_IDLE, S_END: begin
                    if (rx_active_i) begin
                        cnt_q         <= LEN_W'(1);
                        match_local_q <= (rx_data_i == local_mac_i[47:40]);
                        match_bcast_q <= (rx_data_i == 8'hFF);
                        if (wr_full_i) begin
                            state_q <= S_DISCARD;
                        end else begin
                            state_q   <= S_DEST;
                            wr_en_q   <= 1'b1;
                            wr_data_q <= rx_data_i;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end

                S_DEST, S_BODY, S_DISCARD: begin
                    if (!rx_active_i) begin
                        state_q <= S_END;
                        if (good_frame_d) begin
                            commit_q    <= 1'b1;
                            frame_len_q <= cnt_q;
                            good_cnt_q  <= good_inc_d;
                        end else begin
                            abort_q    <= 1'b1;
                            drop_cnt_q <= drop_inc_d;
                        end
                    end else begin
                        cnt_q <= cnt_inc_d;
                        if (state_q == S_DEST) begin
                            match_local_q <= match_local_q & byte_local_d;
                            match_bcast_q <= match_bcast_q & byte_bcast_d;
                            if (wr_full_i) begin
                                state_q <= S_DISCARD;
                            end else begin
                                wr_en_q   <= 1'b1;
                                wr_data_q <= rx_data_i;
                                // Byte 6 is written even when the address
                                // is rejected; the abort rewinds it.
                                if (cnt_q == LEN_W'(5)) begin
                                    state_q <= accept_d ? S_BODY : S_DISCARD;
                                end
                            end
                        end else if (state_q == S_BODY) begin
                            if (wr_full_i || (cnt_inc_d == OvfLen)) begin
                                state_q <= S_DISCARD;
                            end else begin
                                wr_en_q   <= 1'b1;
                                wr_data_q <= rx_data_i;
                            end
                        end
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign wr_en_o        = wr_en_q;
    assign wr_data_o      = wr_data_q;
    assign frame_commit_o = commit_q;
    assign frame_abort_o  = abort_q;
    assign frame_len_o    = frame_len_q;
    assign good_cnt_o     = good_cnt_q;
    assign drop_cnt_o     = drop_cnt_q;

endmodule
